correlate_bank: RTL and testbench
=================================

Name: correlate_bank

Overview:
- Time-multiplexed 1-bit complex correlator with NPAIRS accumulator slots.
- One (a,b) sample pair arrives per valid beat, and consecutive beats address consecutive slots.
- Each slot integrates over passes delimited by first_i/last_i. On the last pass, each slot emits its final real/imag sums as an output stream, with saturation, overflow and framing-error reporting.
- Sits between the sample-pair sequencer and the visibility output buffer, replacing per-pair correlator instances.

Parameters:
- WIDTH, 8, accumulator and output bit-width (>=2).
- NPAIRS, 4, number of time-multiplexed slots (>=1).
- SATURATE, 1, 1 = clamp sums at 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
- SBITS (localparam), max(1, clog2(NPAIRS)), slot index width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  input beat valid; no backpressure
- first_i  in  1  beat belongs to first pass of epoch (overwrite slot)
- last_i  in  1  beat belongs to last pass of epoch (emit slot)
- auto_i  in  1  auto-correlation mode for this beat
- ai_i, aq_i, bi_i, bq_i  in  1 each  sign bits of signals a and b
- valid_o  out  1  output beat valid
- first_o  out  1  output beat is slot 0
- last_o  out  1  output beat is slot NPAIRS-1
- slot_o  out  SBITS  slot index of output beat
- rdata_o  out  WIDTH  real (or a-mean) sum
- idata_o  out  WIDTH  imag (or b-mean) sum
- ovf_o  out  1  this slot saturated/wrapped during the epoch
- misalign_o  out  1  sticky framing-error flag

Behaviour:
- Reset (async, any time, including mid-epoch) clears:
  - all outputs to 0;
  - slot counter to 0;
  - all slot accumulators and per-slot overflow bits to 0;
  - pipeline valid bits and misalign_o to 0.
  - The first beat after reset deassertion is slot 0.
- Slot counter advances by 1 on every valid_i beat and wraps NPAIRS-1 -> 0. No advance when valid_i=0; idle gaps of any length are bubbles with no state change.
- Contribution per beat, with bits={ai_i,aq_i,bi_i,bq_i}:
  - Cross mode (auto_i=0):
    - re = 2 for bits in {0,5,A,F}, 0 for {3,6,9,C}, else 1.
    - im = 2 for {1,7,8,E}, 0 for {2,4,B,D}, else 1.
  - Auto mode (auto_i=1): re = ai_i+aq_i, im = bi_i+bq_i.
  - All contributions are in {0,1,2} and zero-extended to WIDTH.
- Stage 1 (edge 1 after beat): register re, im, slot, first, last, valid.
- Stage 2 (edge 2):
  - Accumulator update for the stage-1 slot:
    - If first, acc = contribution and ovf bit = 0.
    - Else acc = acc + contribution.
  - If acc + contribution > 2^WIDTH-1:
    - SATURATE=1: acc = 2^WIDTH-1.
    - SATURATE=0: acc = low WIDTH bits.
    - In both cases the slot ovf bit is set.
  - first and last on the same beat (single-pass epoch): acc = contribution, and it is emitted.
- Output: at the same edge 2, if the stage-1 beat has last=1:
  - valid_o=1, with rdata_o/idata_o = new acc values, ovf_o = new ovf bit, slot_o = slot.
  - first_o = (slot==0), last_o = (slot==NPAIRS-1).
  - Otherwise valid_o=0, and the data outputs hold their last values.
  - Latency is exactly 2 cycles from input beat to valid_o.
  - One output beat per last-pass input beat.
- Read-modify-write hazard: the bank is registers, read and written in stage 2. With NPAIRS=1, back-to-back beats to slot 0 must accumulate correctly with no stall.
- Framing check:
  - At slot 0 the block latches first_i/last_i.
  - On any valid beat with slot!=0 whose first_i or last_i differs from the latched values, misalign_o goes to 1 and stays there until reset.
  - The beat is still processed using its own flags.
- No backpressure: the consumer must accept every valid_o beat.

Test Plan:
- Reset, NPAIRS=4, WIDTH=8: 3 passes (first, mid, last) of 4 beats each, all bits=0 cross -> 4 output beats, slots 0..3, rdata=6, idata=3, first_o on slot 0, last_o on slot 3, valid_o 2 cycles after each last-pass beat.
- Auto mode, slot 2 bits=F, other slots bits=0, 2 passes -> slot 2 rdata=4 idata=4; other slots rdata=0 idata=0.
- WIDTH=4, SATURATE=1, bits=0 for 9 passes -> rdata=15, ovf_o=1, idata=9, ovf clear in the next epoch. With SATURATE=0 -> rdata=2 (18 mod 16), ovf_o=1.
- Random idle gaps inserted between beats of a 2-pass epoch -> results identical to the gap-free run; slot order unchanged.
- NPAIRS=1: back-to-back single-slot beats bits=3 for 5 passes -> rdata=0, idata=5, every output beat has first_o=last_o=1.
- Assert last_i at slot 2 only of a pass, then assert reset mid-pass -> misalign_o=1, then 0 after reset with all outputs 0, and the next beat lands in slot 0.

Source files
------------

// File: rtl/correlate_bank_if.sv
// Beat interface between the sample-pair sequencer (master) and the correlator bank (slave).
// The same bundle carries the emitted visibility stream back to the master side.
interface correlate_bank_if #(
    parameter int WIDTH  = 8,
    parameter int NPAIRS = 4
);
    localparam int SBITS = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

    logic             valid_i;
    logic             first_i;
    logic             last_i;
    logic             auto_i;
    logic             ai_i;
    logic             aq_i;
    logic             bi_i;
    logic             bq_i;
    logic             valid_o;
    logic             first_o;
    logic             last_o;
    logic [SBITS-1:0] slot_o;
    logic [WIDTH-1:0] rdata_o;
    logic [WIDTH-1:0] idata_o;
    logic             ovf_o;
    logic             misalign_o;

    modport slave (
        input  valid_i, first_i, last_i, auto_i, ai_i, aq_i, bi_i, bq_i,
        output valid_o, first_o, last_o, slot_o, rdata_o, idata_o, ovf_o, misalign_o
    );

    modport master (
        output valid_i, first_i, last_i, auto_i, ai_i, aq_i, bi_i, bq_i,
        input  valid_o, first_o, last_o, slot_o, rdata_o, idata_o, ovf_o, misalign_o
    );
endinterface

// File: rtl/correlate_bank.sv
// Time-multiplexed 1-bit complex correlator: NPAIRS register accumulator slots,
// two-stage pipeline (decode, then read-modify-write + emit on the last pass).
module correlate_bank #(
    parameter int WIDTH    = 8,
    parameter int NPAIRS   = 4,
    parameter int SATURATE = 1
) (
    input  logic             clock,
    input  logic             reset,
    correlate_bank_if.slave  bus
);
    localparam int SBITS = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [WIDTH-1:0] MAXV = '1;

    typedef struct packed {
        logic [1:0]       re;
        logic [1:0]       im;
        logic [SBITS-1:0] slot;
        logic             first;
        logic             last;
    } beat_t;

    logic [SBITS-1:0]             slot;
    logic                         lat_first;
    logic                         lat_last;
    logic [1:0]                   re_c;
    logic [1:0]                   im_c;
    beat_t                        s1;
    logic                         s1_vld;
    logic [NPAIRS-1:0][WIDTH-1:0] acc_r;
    logic [NPAIRS-1:0][WIDTH-1:0] acc_i;
    logic [NPAIRS-1:0]            ovf;
    logic [WIDTH-1:0]             base_r;
    logic [WIDTH-1:0]             base_i;
    logic [WIDTH:0]               sum_r;
    logic [WIDTH:0]               sum_i;
    logic [WIDTH-1:0]             nxt_r;
    logic [WIDTH-1:0]             nxt_i;
    logic                         nxt_ovf;

    // Sign-bit product decode: 2 = agree, 0 = opposite, 1 = quadrature.
    always_comb begin
        re_c = 2'd1;
        im_c = 2'd1;
        if (bus.auto_i) begin
            re_c = {1'b0, bus.ai_i} + {1'b0, bus.aq_i};
            im_c = {1'b0, bus.bi_i} + {1'b0, bus.bq_i};
        end else begin
            case ({bus.ai_i, bus.aq_i, bus.bi_i, bus.bq_i})
                4'h0, 4'h5, 4'hA, 4'hF: re_c = 2'd2;
                4'h3, 4'h6, 4'h9, 4'hC: re_c = 2'd0;
                default:                re_c = 2'd1;
            endcase
            case ({bus.ai_i, bus.aq_i, bus.bi_i, bus.bq_i})
                4'h1, 4'h7, 4'h8, 4'hE: im_c = 2'd2;
                4'h2, 4'h4, 4'hB, 4'hD: im_c = 2'd0;
                default:                im_c = 2'd1;
            endcase
        end
    end

    // Read and write of the bank both happen in stage 2, so back-to-back
    // beats to one slot see the freshly written value without forwarding.
    always_comb begin
        base_r  = s1.first ? '0 : acc_r[s1.slot];
        base_i  = s1.first ? '0 : acc_i[s1.slot];
        sum_r   = {1'b0, base_r} + {{(WIDTH-1){1'b0}}, s1.re};
        sum_i   = {1'b0, base_i} + {{(WIDTH-1){1'b0}}, s1.im};
        nxt_r   = (sum_r[WIDTH] && SATURATE != 0) ? MAXV : sum_r[WIDTH-1:0];
        nxt_i   = (sum_i[WIDTH] && SATURATE != 0) ? MAXV : sum_i[WIDTH-1:0];
        nxt_ovf = (!s1.first && ovf[s1.slot]) || sum_r[WIDTH] || sum_i[WIDTH];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot           <= '0;
            lat_first      <= 1'b0;
            lat_last       <= 1'b0;
            s1             <= '0;
            s1_vld         <= 1'b0;
            acc_r          <= '0;
            acc_i          <= '0;
            ovf            <= '0;
            bus.valid_o    <= 1'b0;
            bus.first_o    <= 1'b0;
            bus.last_o     <= 1'b0;
            bus.slot_o     <= '0;
            bus.rdata_o    <= '0;
            bus.idata_o    <= '0;
            bus.ovf_o      <= 1'b0;
            bus.misalign_o <= 1'b0;
        end else begin
            s1_vld <= bus.valid_i;
            if (bus.valid_i) begin
                s1   <= '{re: re_c, im: im_c, slot: slot, first: bus.first_i, last: bus.last_i};
                slot <= (slot == SBITS'(NPAIRS - 1)) ? '0 : slot + SBITS'(1);
                // Slot 0 sets the pass framing; every other slot must agree with it.
                if (slot == '0) begin
                    lat_first <= bus.first_i;
                    lat_last  <= bus.last_i;
                end else if (bus.first_i != lat_first || bus.last_i != lat_last) begin
                    bus.misalign_o <= 1'b1;
                end
            end

            bus.valid_o <= s1_vld && s1.last;
            if (s1_vld) begin
                acc_r[s1.slot] <= nxt_r;
                acc_i[s1.slot] <= nxt_i;
                ovf[s1.slot]   <= nxt_ovf;
                if (s1.last) begin
                    bus.first_o <= (s1.slot == '0);
                    bus.last_o  <= (s1.slot == SBITS'(NPAIRS - 1));
                    bus.slot_o  <= s1.slot;
                    bus.rdata_o <= nxt_r;
                    bus.idata_o <= nxt_i;
                    bus.ovf_o   <= nxt_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_correlate_bank.sv
// Drives four correlator configurations with one shared beat stream and checks each
// against a complex-arithmetic reference model plus hand-derived constants.
module tb_correlate_bank;
    // cfg0: W8 N4 sat, cfg1: W4 N4 sat, cfg2: W4 N4 wrap, cfg3: W8 N1 sat
    localparam logic [3:0][7:0] WS = {8'd8, 8'd4, 8'd4, 8'd8};
    localparam logic [3:0][7:0] NS = {8'd1, 8'd4, 8'd4, 8'd4};
    localparam logic [3:0]      SS = 4'b1011;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic valid, first, last, au, ai, aq, bi, bq;

    logic [3:0]       o_valid, o_first, o_last, o_ovf, o_mis;
    logic [3:0][1:0]  o_slot;
    logic [3:0][7:0]  o_r, o_i;

    always #5 clock = ~clock;

    for (genvar c = 0; c < 4; c++) begin : g_cfg
        correlate_bank_if #(.WIDTH(int'(WS[c])), .NPAIRS(int'(NS[c]))) ifc ();
        correlate_bank #(.WIDTH(int'(WS[c])), .NPAIRS(int'(NS[c])), .SATURATE(int'(SS[c]))) dut (
            .clock(clock), .reset(reset), .bus(ifc.slave));
        assign ifc.valid_i = valid;
        assign ifc.first_i = first;
        assign ifc.last_i  = last;
        assign ifc.auto_i  = au;
        assign ifc.ai_i    = ai;
        assign ifc.aq_i    = aq;
        assign ifc.bi_i    = bi;
        assign ifc.bq_i    = bq;
        assign o_valid[c]  = ifc.valid_o;
        assign o_first[c]  = ifc.first_o;
        assign o_last[c]   = ifc.last_o;
        assign o_ovf[c]    = ifc.ovf_o;
        assign o_mis[c]    = ifc.misalign_o;
        assign o_slot[c]   = 2'(ifc.slot_o);
        assign o_r[c]      = 8'(ifc.rdata_o);
        assign o_i[c]      = 8'(ifc.idata_o);
    end

    typedef struct {
        bit v;
        int slot;
        bit f, l;
        int r, i;
        bit ovf;
    } exp_t;

    typedef struct {
        bit       a;
        bit [3:0] bits;
        int       re, im;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t e_now[4], e_prev[4];
    int   m_r[4][4], m_i[4][4], m_slot[4];
    bit   m_ovf[4][4], m_lf[4], m_ll[4], m_mis[4];
    int   got_r[4][4], got_i[4][4], got_f[4][4], got_l[4][4], got_o[4][4];

    task automatic chk(input string nm, input int c, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cfg%0d got=%0d expected=%0d at %0t", nm, c, got, exp, $time);
        end
    endtask

    // Sign bits as +/-1 complex samples; correlation = a * conj(b), mapped {-2,0,2} -> {0,1,2}.
    function automatic void contrib(input bit a, input bit [3:0] b, output int re, output int im);
        int ar, aqv, br, bqv;
        if (a) begin
            re = int'(b[3]) + int'(b[2]);
            im = int'(b[1]) + int'(b[0]);
        end else begin
            ar  = b[3] ? -1 : 1;
            aqv = b[2] ? -1 : 1;
            br  = b[1] ? -1 : 1;
            bqv = b[0] ? -1 : 1;
            re  = (ar * br + aqv * bqv + 2) / 2;
            im  = (aqv * br - ar * bqv + 2) / 2;
        end
    endfunction

    task automatic model_beat(input bit f, input bit l, input bit a, input bit [3:0] bits);
        int re, im, s, mx, nr, ni;
        bit o;
        contrib(a, bits, re, im);
        for (int c = 0; c < 4; c++) begin
            s  = m_slot[c];
            mx = (1 << int'(WS[c])) - 1;
            if (s == 0) begin
                m_lf[c] = f;
                m_ll[c] = l;
            end else if (f != m_lf[c] || l != m_ll[c]) begin
                m_mis[c] = 1'b1;
            end
            nr = (f ? 0 : m_r[c][s]) + re;
            ni = (f ? 0 : m_i[c][s]) + im;
            o  = f ? 1'b0 : m_ovf[c][s];
            if (nr > mx) begin o = 1'b1; nr = SS[c] ? mx : nr % (mx + 1); end
            if (ni > mx) begin o = 1'b1; ni = SS[c] ? mx : ni % (mx + 1); end
            m_r[c][s] = nr;
            m_i[c][s] = ni;
            m_ovf[c][s] = o;
            if (l) e_now[c] = '{v: 1'b1, slot: s, f: (s == 0), l: (s == int'(NS[c]) - 1),
                                r: nr, i: ni, ovf: o};
            m_slot[c] = (s + 1) % int'(NS[c]);
        end
    endtask

    task automatic check_outs();
        for (int c = 0; c < 4; c++) begin
            chk("valid_o", c, int'(o_valid[c]), int'(e_prev[c].v));
            chk("misalign_o", c, int'(o_mis[c]), int'(m_mis[c]));
            if (e_prev[c].v && o_valid[c]) begin
                chk("slot_o", c, int'(o_slot[c]), e_prev[c].slot);
                chk("first_o", c, int'(o_first[c]), int'(e_prev[c].f));
                chk("last_o", c, int'(o_last[c]), int'(e_prev[c].l));
                chk("rdata_o", c, int'(o_r[c]), e_prev[c].r);
                chk("idata_o", c, int'(o_i[c]), e_prev[c].i);
                chk("ovf_o", c, int'(o_ovf[c]), int'(e_prev[c].ovf));
                got_r[c][o_slot[c]] = int'(o_r[c]);
                got_i[c][o_slot[c]] = int'(o_i[c]);
                got_f[c][o_slot[c]] = int'(o_first[c]);
                got_l[c][o_slot[c]] = int'(o_last[c]);
                got_o[c][o_slot[c]] = int'(o_ovf[c]);
            end
        end
    endtask

    // Apply one beat (or bubble), advance one cycle, check the beat from one cycle earlier.
    task automatic step(input bit v, input bit f, input bit l, input bit a, input bit [3:0] bits);
        valid = v; first = f; last = l; au = a;
        {ai, aq, bi, bq} = bits;
        for (int c = 0; c < 4; c++) e_now[c].v = 1'b0;
        if (v) model_beat(f, l, a, bits);
        @(posedge clock);
        @(negedge clock);
        check_outs();
        e_prev = e_now;
    endtask

    task automatic pass(input bit f, input bit l, input bit a, input logic [15:0] bv, input int maxgap);
        for (int s = 0; s < 4; s++) begin
            step(1'b1, f, l, a, bv[4*s +: 4]);
            repeat ($urandom_range(maxgap, 0)) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        end
    endtask

    task automatic do_reset();
        valid = 0; first = 0; last = 0; au = 0; {ai, aq, bi, bq} = 4'h0;
        #2 reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rst_valid", c, int'(o_valid[c]), 0);
            chk("rst_first", c, int'(o_first[c]), 0);
            chk("rst_last", c, int'(o_last[c]), 0);
            chk("rst_slot", c, int'(o_slot[c]), 0);
            chk("rst_rdata", c, int'(o_r[c]), 0);
            chk("rst_idata", c, int'(o_i[c]), 0);
            chk("rst_ovf", c, int'(o_ovf[c]), 0);
            chk("rst_misalign", c, int'(o_mis[c]), 0);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_slot[c] = 0; m_lf[c] = 0; m_ll[c] = 0; m_mis[c] = 0;
            e_now[c] = '{v: 1'b0, slot: 0, f: 1'b0, l: 1'b0, r: 0, i: 0, ovf: 1'b0};
            e_prev[c] = e_now[c];
            for (int s = 0; s < 4; s++) begin
                m_r[c][s] = 0; m_i[c][s] = 0; m_ovf[c][s] = 0;
                got_r[c][s] = -1; got_i[c][s] = -1; got_f[c][s] = -1;
                got_l[c][s] = -1; got_o[c][s] = -1;
            end
        end
    endtask

    vec_t vecs[20];
    logic [15:0] bv;
    int ere, eim;

    initial begin
        vecs = '{
            '{0, 4'h0, 2, 1}, '{0, 4'h1, 1, 2}, '{0, 4'h2, 1, 0}, '{0, 4'h3, 0, 1},
            '{0, 4'h4, 1, 0}, '{0, 4'h5, 2, 1}, '{0, 4'h6, 0, 1}, '{0, 4'h7, 1, 2},
            '{0, 4'h8, 1, 2}, '{0, 4'h9, 0, 1}, '{0, 4'hA, 2, 1}, '{0, 4'hB, 1, 0},
            '{0, 4'hC, 0, 1}, '{0, 4'hD, 1, 0}, '{0, 4'hE, 1, 2}, '{0, 4'hF, 2, 1},
            '{1, 4'h9, 1, 1}, '{1, 4'hF, 2, 2}, '{1, 4'h6, 1, 1}, '{1, 4'hC, 2, 0}};

        do_reset();

        // Three passes of all-zero cross bits.
        pass(1, 0, 0, 16'h0000, 0);
        pass(0, 0, 0, 16'h0000, 0);
        pass(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            chk("p3_rdata", 0, got_r[0][s], 6);
            chk("p3_idata", 0, got_i[0][s], 3);
            chk("p3_first", 0, got_f[0][s], int'(s == 0));
            chk("p3_last", 0, got_l[0][s], int'(s == 3));
        end

        // Auto mode, only slot 2 active.
        do_reset();
        pass(1, 0, 1, 16'h0F00, 0);
        pass(0, 1, 1, 16'h0F00, 0);
        step(0, 0, 0, 0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            chk("auto_rdata", 0, got_r[0][s], (s == 2) ? 4 : 0);
            chk("auto_idata", 0, got_i[0][s], (s == 2) ? 4 : 0);
        end

        // Nine passes to push the narrow configs past full scale.
        do_reset();
        for (int p = 0; p < 9; p++) pass(p == 0, p == 8, 0, 16'h0000, 0);
        step(0, 0, 0, 0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            chk("sat_rdata", 1, got_r[1][s], 15);
            chk("sat_ovf", 1, got_o[1][s], 1);
            chk("sat_idata", 1, got_i[1][s], 9);
            chk("wrap_rdata", 2, got_r[2][s], 2);
            chk("wrap_ovf", 2, got_o[2][s], 1);
            chk("wide_rdata", 0, got_r[0][s], 18);
            chk("wide_ovf", 0, got_o[0][s], 0);
        end
        pass(1, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            chk("next_ovf", 1, got_o[1][s], 0);
            chk("next_rdata", 1, got_r[1][s], 2);
        end

        // Two-pass epoch with random bubbles between beats.
        do_reset();
        bv = 16'($urandom);
        pass(1, 0, 0, bv, 3);
        pass(0, 1, 0, bv, 3);
        step(0, 0, 0, 0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            contrib(1'b0, bv[4*s +: 4], ere, eim);
            chk("gap_rdata", 0, got_r[0][s], 2 * ere);
            chk("gap_idata", 0, got_i[0][s], 2 * eim);
        end

        // Single-slot config, back-to-back beats to slot 0.
        do_reset();
        for (int p = 0; p < 5; p++) step(1, p == 0, p == 4, 0, 4'h3);
        step(0, 0, 0, 0, 4'h0);
        chk("n1_rdata", 3, got_r[3][0], 0);
        chk("n1_idata", 3, got_i[3][0], 5);
        chk("n1_first", 3, got_f[3][0], 1);
        chk("n1_last", 3, got_l[3][0], 1);

        // last_i raised only at slot 2, then reset mid-pass.
        do_reset();
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 1, 0, 4'h0);
        chk("mis_set", 0, int'(o_mis[0]), 1);
        do_reset();
        step(1, 1, 1, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("post_rst_slot", 0, int'(o_slot[0]), 0);
        chk("post_rst_first", 0, int'(o_first[0]), 1);
        chk("post_rst_rdata", 0, int'(o_r[0]), 2);

        // Contribution table, single-pass epochs on the one-slot config.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 1, vecs[k].a, vecs[k].bits);
            step(0, 0, 0, 0, 4'h0);
            chk("tbl_re", 3, int'(o_r[3]), vecs[k].re);
            chk("tbl_im", 3, int'(o_i[3]), vecs[k].im);
        end

        // Random beats, flags and bubbles against the model.
        do_reset();
        for (int k = 0; k < 400; k++)
            step(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 1'($urandom), 4'($urandom));
        step(0, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
